// File: rtl/arb_pkg.sv
// Shared encodings for the memory arbiter: core op codes, arbiter FSM states
// and the watchdog counter width.
package arb_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RDEX = 2'b11
  } arb_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_RESP = 2'b10
  } arb_state_t;

  localparam int NUM_PROCS = 4;
  localparam int CNT_W     = 8;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 4-way round-robin picker: first eligible requester scanning
// ptr, ptr+1, ... modulo 4.
module rr_pick (
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    gnt_id = ptr;
    any    = 1'b0;
    cand   = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (elig[cand]) begin
        gnt_id = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among four cores, with a
// watchdog that aborts transactions the memory side never acknowledges.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    plusclk,
  input  logic                    rst,
  input  logic [3:0]              req,
  input  logic [7:0]              req_op,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_req,
  output logic [1:0]              mem_op,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [1:0]              mem_id,
  output logic                    busy,
  output logic [3:0]              done,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [3:0]              stall,
  output arb_state_t              dbg_state,
  output logic [1:0]              dbg_ptr
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t           state;
  logic [1:0]           ptr;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           elig;
  logic [1:0]           pick_id;
  logic                 pick_any;
  logic [1:0]           op_a    [NUM_PROCS];
  logic [ADDR_WIDTH-1:0] addr_a [NUM_PROCS];
  logic [DATA_WIDTH-1:0] wdata_a[NUM_PROCS];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PROCS; i++) begin
      op_a[i]    = req_op[2*i +: 2];
      addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      elig[i]    = req[i] && (op_a[i] != OP_NOP);
    end
  end

  rr_pick u_pick (
    .elig   (elig),
    .ptr    (ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  // A core stays stalled until the cycle its completion pulse is presented.
  always_comb begin
    stall = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_PROCS; i++) begin
        stall[i] = elig[i] && !(state == S_RESP && mem_id == 2'(i));
      end
    end
  end

  // Memory handshake: mem_req holds the latched fields stable for every BUSY
  // cycle; the transaction completes on the first rising edge with mem_ack=1.
  always_ff @(posedge plusclk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_op    <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_id    <= 2'd0;
      busy      <= 1'b0;
      done      <= 4'b0000;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 4'b0000;
          err  <= 1'b0;
          if (pick_any) begin
            mem_id    <= pick_id;
            mem_op    <= op_a[pick_id];
            mem_addr  <= addr_a[pick_id];
            mem_wdata <= wdata_a[pick_id];
            cnt       <= '0;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            rdata   <= mem_rdata;
            err     <= 1'b0;
            done    <= 4'b0001 << mem_id;
            mem_req <= 1'b0;
            state   <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rdata   <= '0;
            err     <= 1'b1;
            done    <= 4'b0001 << mem_id;
            mem_req <= 1'b0;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          done  <= 4'b0000;
          err   <= 1'b0;
          busy  <= 1'b0;
          ptr   <= mem_id + 2'd1;
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 4'b0000;
          err     <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level round-robin model
// predicts grant order, latched fields, completion latency, err and rdata.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TO = 4;

  typedef struct packed {
    logic [1:0]    id;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0]    id;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    len;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct packed {
    logic [7:0]    d;
    logic [DW-1:0] r;
  } plan_t;

  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [3:0]      req       = '0;
  logic [7:0]      req_op    = '0;
  logic [4*AW-1:0] req_addr  = '0;
  logic [4*DW-1:0] req_wdata = '0;
  logic            mem_ack   = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            mem_req;
  logic [1:0]      mem_op;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [1:0]      mem_id;
  logic            busy;
  logic [3:0]      done;
  logic            err;
  logic [DW-1:0]   rdata;
  logic [3:0]      stall;
  arb_state_t      dbg_state;
  logic [1:0]      dbg_ptr;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .plusclk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_id(mem_id), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .stall(stall), .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // ---------------- shared state ----------------
  logic [EXP_W-1:0] exp_q[$];
  txn_t             all_q[$];
  txn_t             stage_q[$];
  plan_t            plan_q[$];
  int unsigned      dly_q[$];
  logic [DW-1:0]    rd_q[$];
  int tests = 0;
  int fails = 0;
  int ptr_m = 0;
  int flush_cnt = 0;
  int resp_mode = 0;
  bit mon_en = 1'b0;
  bit in_txn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- core drivers ----------------
  int  drv_flush_seen = 0;
  logic [3:0] pop_pend = '0;
  always @(negedge clk) begin : drv
    bit found;
    if (flush_cnt != drv_flush_seen) begin
      pop_pend = '0;
      drv_flush_seen = flush_cnt;
    end
    for (int i = 0; i < 4; i++) begin
      if (pop_pend[i]) begin
        pop_pend[i] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < all_q.size(); k++) begin
          if (!found && all_q[k].id == 2'(i)) begin
            all_q.delete(k);
            found = 1'b1;
          end
        end
      end
      if (done[i]) pop_pend[i] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int k = 0; k < all_q.size(); k++) begin
        if (!found && all_q[k].id == 2'(i)) begin
          found = 1'b1;
          req[i] = 1'b1;
          req_op[2*i +: 2] = all_q[k].op;
          req_addr[i*AW +: AW] = all_q[k].addr;
          req_wdata[i*DW +: DW] = all_q[k].wdata;
        end
      end
      if (!found) begin
        req[i] = 1'b0;
        req_op[2*i +: 2] = 2'b00;
      end
      // Scramble the owner's fields mid-transaction; the latched copy must hold.
      if (mem_req && mem_id == 2'(i)) begin
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = DW'($urandom);
      end
    end
  end

  // ---------------- memory responder ----------------
  bit    r_act = 1'b0;
  int    jcnt = 0;
  plan_t pcur;
  always @(negedge clk) begin
    if (resp_mode == 1) begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      r_act = 1'b0;
    end else if (resp_mode == 2) begin
      mem_ack = 1'b1;
      mem_rdata = DW'($urandom);
      r_act = 1'b0;
    end else if (mem_req) begin
      if (!r_act) begin
        r_act = 1'b1;
        jcnt = 0;
        if (plan_q.size() > 0) pcur = plan_q.pop_front();
        else begin
          pcur.d = 8'hFF;
          pcur.r = '0;
        end
      end
      mem_ack = (jcnt == int'(pcur.d));
      mem_rdata = mem_ack ? pcur.r : DW'($urandom);
      jcnt++;
    end else begin
      r_act = 1'b0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int   mon_flush_seen = 0;
  int   bcnt = 0;
  exp_t cur;
  always @(negedge clk) begin : mon
    logic       resp_now;
    logic [3:0] nonnop;
    logic [3:0] stall_exp;
    #1;
    if (flush_cnt != mon_flush_seen) begin
      in_txn = 1'b0;
      mon_flush_seen = flush_cnt;
    end
    if (mon_en) begin
      resp_now = 1'b0;
      if (!in_txn) begin
        if (mem_req) begin
          if (exp_q.size() == 0) check("unexpected_txn", 64'(mem_req), 64'(0));
          else begin
            cur = exp_t'(exp_q.pop_front());
            in_txn = 1'b1;
            bcnt = 0;
          end
        end else begin
          check("idle_done", 64'(done), 64'(0));
          check("idle_busy", 64'(busy), 64'(0));
        end
      end
      if (in_txn) begin
        if (bcnt < int'(cur.len)) begin
          check("busy_mem_req", 64'(mem_req), 64'(1));
          check("busy_done", 64'(done), 64'(0));
          check("mem_id", 64'(mem_id), 64'(cur.id));
          check("mem_op", 64'(mem_op), 64'(cur.op));
          check("mem_addr", 64'(mem_addr), 64'(cur.addr));
          check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
          bcnt++;
        end else begin
          resp_now = 1'b1;
          check("resp_mem_req", 64'(mem_req), 64'(0));
          check("resp_busy", 64'(busy), 64'(1));
          check("done", 64'(done), 64'(4'b0001 << cur.id));
          check("err", 64'(err), 64'(cur.err));
          check("rdata", 64'(rdata), 64'(cur.rdata));
          in_txn = 1'b0;
        end
      end
      for (int i = 0; i < 4; i++) nonnop[i] = (req_op[2*i +: 2] != 2'b00);
      stall_exp = req & nonnop;
      if (resp_now) stall_exp = stall_exp & ~(4'b0001 << cur.id);
      if (rst) stall_exp = 4'b0000;
      check("stall", 64'(stall), 64'(stall_exp));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic stage(input int id, input int op, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    txn_t t;
    t.id = 2'(id);
    t.op = 2'(op);
    t.addr = addr;
    t.wdata = wdata;
    stage_q.push_back(t);
  endtask

  task automatic recover();
    flush_cnt++;
    exp_q.delete();
    plan_q.delete();
    all_q.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ptr_m = 0;
    tick();
  endtask

  // Reference model: serve the staged set in round-robin order from ptr_m.
  task automatic run_batch(input string name);
    txn_t pend[$];
    txn_t t;
    exp_t e;
    plan_t p;
    int sel;
    int cid;
    int d;
    int n;
    pend = stage_q;
    while (pend.size() > 0) begin
      sel = -1;
      for (int k = 0; k < 4; k++) begin
        cid = (ptr_m + k) % 4;
        for (int m = 0; m < pend.size(); m++)
          if (sel < 0 && int'(pend[m].id) == cid) sel = m;
      end
      t = pend[sel];
      pend.delete(sel);
      d = (dly_q.size() > 0) ? int'(dly_q.pop_front()) : int'($urandom_range(0, TO + 1));
      p.d = 8'(d);
      p.r = (rd_q.size() > 0) ? rd_q.pop_front() : DW'($urandom);
      e.id = t.id;
      e.op = t.op;
      e.addr = t.addr;
      e.wdata = t.wdata;
      e.len = 8'((d + 1 < TO) ? d + 1 : TO);
      e.err = (d >= TO);
      e.rdata = e.err ? '0 : p.r;
      exp_q.push_back(e);
      plan_q.push_back(p);
      ptr_m = (int'(t.id) + 1) % 4;
    end
    foreach (stage_q[k]) all_q.push_back(stage_q[k]);
    stage_q.delete();
    n = 0;
    while ((exp_q.size() != 0 || in_txn || all_q.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size() + all_q.size() + int'(in_txn)), 64'(0));
    if (n >= 400) recover();
    tick();
    check({name, "_ptr"}, 64'(dbg_ptr), 64'(ptr_m));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt_c;
    int total;
    int n;
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("rst_ptr", 64'(dbg_ptr), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_op", 64'(mem_op), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_mem_id", 64'(mem_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // All four cores write at once with immediate ack.
    for (int i = 0; i < 4; i++) begin
      stage(i, 2, AW'(32'h100 + 4 * i), DW'(8'hF0 + i));
      dly_q.push_back(0);
    end
    run_batch("all_wr");

    // Single read from core 2, ack in the second BUSY cycle.
    stage(2, 1, AW'(32'h000C), DW'(0));
    dly_q.push_back(1);
    rd_q.push_back(8'h15);
    run_batch("single_rd");

    // Fairness with ptr at 3: core 3 twice, core 0 once.
    stage(3, 1, AW'(32'h30), DW'(8'h33));
    stage(3, 3, AW'(32'h34), DW'(8'h34));
    stage(0, 2, AW'(32'h40), DW'(8'h40));
    run_batch("fair");

    // Watchdog: no ack, then ack in the last allowed BUSY cycle.
    stage(1, 1, AW'(32'h50), DW'(0));
    dly_q.push_back(TO + 1);
    run_batch("timeout");
    stage(1, 3, AW'(32'h54), DW'(0));
    dly_q.push_back(TO - 1);
    rd_q.push_back(8'hA5);
    run_batch("ack_at_limit");

    for (int b = 0; b < 30; b++) begin
      total = 0;
      for (int i = 0; i < 4; i++) begin
        cnt_c = $urandom_range(0, 2);
        for (int c = 0; c < cnt_c; c++)
          stage(i, $urandom_range(1, 3), AW'($urandom), DW'($urandom));
        total += cnt_c;
      end
      if (total == 0) stage($urandom_range(0, 3), $urandom_range(1, 3), AW'($urandom), DW'($urandom));
      run_batch("rand");
    end

    // NOP request never wins and never stalls.
    stage(1, 0, AW'(32'h60), DW'(0));
    foreach (stage_q[k]) all_q.push_back(stage_q[k]);
    stage_q.delete();
    for (int c = 0; c < 6; c++) begin
      tick();
      check("nop_busy", 64'(busy), 64'(0));
      check("nop_stall", 64'(stall[1]), 64'(0));
    end
    all_q.delete();
    tick();
    tick();

    // Reset in the second BUSY cycle; a later ack must be ignored.
    mon_en = 1'b0;
    resp_mode = 1;
    stage(1, 1, AW'(32'h70), DW'(0));
    foreach (stage_q[k]) all_q.push_back(stage_q[k]);
    stage_q.delete();
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check("rstmid_start", 64'(mem_req), 64'(1));
    tick();
    check("rstmid_busy2", 64'(dbg_state), 64'(S_BUSY));
    rst = 1'b1;
    tick();
    check("rstmid_state", 64'(dbg_state), 64'(S_IDLE));
    check("rstmid_mem_req", 64'(mem_req), 64'(0));
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_done", 64'(done), 64'(0));
    check("rstmid_err", 64'(err), 64'(0));
    check("rstmid_stall", 64'(stall), 64'(0));
    all_q.delete();
    tick();
    rst = 1'b0;
    ptr_m = 0;
    resp_mode = 2;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("late_ack_done", 64'(done), 64'(0));
      check("late_ack_busy", 64'(busy), 64'(0));
    end
    resp_mode = 0;
    mon_en = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) stage(i, $urandom_range(1, 3), AW'($urandom), DW'($urandom));
    run_batch("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
